// File: rtl/ps2_note_mapper.sv
// Turns PS/2 make/break keycodes into MIDI note-on/off events for the synth voice allocator.
// One key per clock flows decode -> note logic -> show-ahead event FIFO.
module ps2_note_mapper #(
    parameter int BASE_NOTE = 36,
    parameter int OCT_INIT  = 2,
    parameter int OCT_MAX   = 4,
    parameter int FIFO_AW   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keycode,
    input  logic        key_valid,
    input  logic        ev_ready,
    output logic        ev_valid,
    output logic [6:0]  ev_note,
    output logic        ev_on,
    output logic [12:0] held,
    output logic [2:0]  octave,
    output logic        overflow
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] KIND_NONE   = 2'd0;
    localparam logic [1:0] KIND_NOTE   = 2'd1;
    localparam logic [1:0] KIND_OCT_UP = 2'd2;
    localparam logic [1:0] KIND_OCT_DN = 2'd3;

    // Stage 1: decoded key; an idle cycle is encoded as KIND_NONE.
    logic [1:0] kind_c;
    logic [3:0] idx_c;
    logic [1:0] dec_kind;
    logic [3:0] dec_idx;
    logic       dec_is_break;

    always_comb begin
        kind_c = KIND_NOTE;
        idx_c  = 4'd0;
        case (keycode[7:0])
            8'h1C: idx_c = 4'd0;
            8'h1D: idx_c = 4'd1;
            8'h1B: idx_c = 4'd2;
            8'h24: idx_c = 4'd3;
            8'h23: idx_c = 4'd4;
            8'h2B: idx_c = 4'd5;
            8'h2C: idx_c = 4'd6;
            8'h34: idx_c = 4'd7;
            8'h35: idx_c = 4'd8;
            8'h33: idx_c = 4'd9;
            8'h3C: idx_c = 4'd10;
            8'h3B: idx_c = 4'd11;
            8'h42: idx_c = 4'd12;
            8'h22: kind_c = KIND_OCT_UP;
            8'h1A: kind_c = KIND_OCT_DN;
            default: kind_c = KIND_NONE;
        endcase
        if (!key_valid) begin
            kind_c = KIND_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_kind     <= KIND_NONE;
            dec_idx      <= 4'd0;
            dec_is_break <= 1'b0;
        end else begin
            dec_kind     <= kind_c;
            dec_idx      <= idx_c;
            dec_is_break <= (keycode[15:8] == 8'hF0);
        end
    end

    // FIFO bookkeeping
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               pop;
    logic               can_push;

    assign full     = (count == (FIFO_AW+1)'(DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid & ev_ready;
    assign can_push = ~full | pop;
    assign ev_note  = ev_valid ? mem[rd_ptr][7:1] : 7'd0;
    assign ev_on    = ev_valid & mem[rd_ptr][0];

    // Stage 2: note/octave decisions
    logic [6:0]  note_r [13];
    logic [6:0]  note_calc;
    logic        push;
    logic [7:0]  push_data;
    logic        set_note;
    logic [12:0] held_nxt;
    logic [2:0]  oct_nxt;
    logic        ovf_nxt;

    assign note_calc = 7'(BASE_NOTE) + 7'(octave) * 7'd12 + 7'(dec_idx);

    always_comb begin
        push      = 1'b0;
        push_data = 8'd0;
        set_note  = 1'b0;
        held_nxt  = held;
        oct_nxt   = octave;
        ovf_nxt   = overflow;
        case (dec_kind)
            KIND_NOTE: begin
                if (!dec_is_break && !held[dec_idx]) begin
                    if (can_push) begin
                        push              = 1'b1;
                        push_data         = {note_calc, 1'b1};
                        set_note          = 1'b1;
                        held_nxt[dec_idx] = 1'b1;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end else if (dec_is_break && held[dec_idx]) begin
                    // A break always releases the key, even if its event is lost.
                    held_nxt[dec_idx] = 1'b0;
                    if (can_push) begin
                        push      = 1'b1;
                        push_data = {note_r[dec_idx], 1'b0};
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end
            end
            KIND_OCT_UP: begin
                if (!dec_is_break && octave < 3'(OCT_MAX)) begin
                    oct_nxt = octave + 3'd1;
                end
            end
            KIND_OCT_DN: begin
                if (!dec_is_break && octave != 3'd0) begin
                    oct_nxt = octave - 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held     <= 13'd0;
            octave   <= 3'(OCT_INIT);
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            held     <= held_nxt;
            octave   <= oct_nxt;
            overflow <= ovf_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage arrays carry no reset; held and count gate every read.
    always_ff @(posedge clk) begin
        if (set_note) begin
            note_r[dec_idx] <= note_calc;
        end
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule
